// File: rtl/mem_port_arbiter_if.sv
// Memory request/response port (sram-like): req/addr_ok handshake, then one data_ok response.
// The master drives the request. The slave answers with addr_ok, data_ok and rdata.
interface mem_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output wr,
        output wstrb,
        output addr,
        output wdata,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  wstrb,
        input  addr,
        input  wdata,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one bus port between the fetch port and the data port.
// One transaction is in flight at a time. A cancelled fetch completes on the bus but is dropped.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_cancel,
    mem_port_arbiter_if.slave  inst,
    mem_port_arbiter_if.slave  data,
    mem_port_arbiter_if.master bus
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       cancelled;
    logic [3:0] starve_cnt;
    logic       inst_win;
    logic       inst_grant;
    logic       data_grant;
    logic       in_wait;
    logic       unused_inst;

    assign unused_inst = ^{inst.wr, inst.wstrb, inst.wdata};

    // Data wins unless it is absent or fetch has been passed over too often.
    always_comb begin
        inst_win = inst.req & (~data.req | (starve_cnt == SMAX));
    end

    // Next state and grant pulses; grants happen only from IDLE.
    always_comb begin
        state_nxt  = state;
        inst_grant = 1'b0;
        data_grant = 1'b0;
        unique case (state)
            IDLE: begin
                if (inst.req | data.req) begin
                    state_nxt  = ADDR;
                    inst_grant = inst_win;
                    data_grant = ~inst_win;
                end
            end
            ADDR: begin
                if (bus.addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign inst.addr_ok = inst_grant;
    assign data.addr_ok = data_grant;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winner's payload and hold it until the bus accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.req   <= 1'b0;
            bus.wr    <= 1'b0;
            bus.wstrb <= 4'h0;
            bus.addr  <= 32'h0;
            bus.wdata <= 32'h0;
            owner     <= 1'b0;
        end else if (inst_grant) begin
            bus.req   <= 1'b1;
            bus.wr    <= 1'b0;
            bus.wstrb <= 4'h0;
            bus.addr  <= inst.addr;
            bus.wdata <= 32'h0;
            owner     <= 1'b0;
        end else if (data_grant) begin
            bus.req   <= 1'b1;
            bus.wr    <= data.wr;
            bus.wstrb <= data.wr ? data.wstrb : 4'h0;
            bus.addr  <= data.addr;
            bus.wdata <= data.wdata;
            owner     <= 1'b1;
        end else if ((state == ADDR) && bus.addr_ok) begin
            bus.req   <= 1'b0;
        end
    end

    // Remember a flush against an in-flight fetch until the bus answers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancelled <= 1'b0;
        end else if (state_nxt == IDLE) begin
            cancelled <= 1'b0;
        end else if ((state != IDLE) && ~owner && inst_cancel) begin
            cancelled <= 1'b1;
        end
    end

    // Count data grants that overtook a waiting fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'h0;
        end else if (inst_grant) begin
            starve_cnt <= 4'h0;
        end else if (data_grant && inst.req && (starve_cnt != SMAX)) begin
            starve_cnt <= starve_cnt + 4'h1;
        end
    end

    // Route the bus response to its owner; drop a flushed fetch.
    always_comb begin
        in_wait      = (state == WAIT);
        inst.data_ok = in_wait & bus.data_ok & ~owner
                     & ~cancelled & ~inst_cancel;
        data.data_ok = in_wait & bus.data_ok & owner;
        inst.rdata   = bus.rdata;
        data.rdata   = bus.rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset;
    logic inst_cancel;

    mem_port_arbiter_if inst_if ();
    mem_port_arbiter_if data_if ();
    mem_port_arbiter_if bus_if ();

    mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_cancel(inst_cancel),
        .inst       (inst_if),
        .data       (data_if),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit pend = 1'b0;

    typedef struct {
        bit          is_data;
        bit          wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          exp_wr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vt [6];
    logic [31:0] mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic edge_t();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        inst_if.req = 0; inst_if.addr = 0; inst_if.wr = 0;
        inst_if.wstrb = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.addr = 0; data_if.wr = 0;
        data_if.wstrb = 0; data_if.wdata = 0;
        bus_if.addr_ok = 0; bus_if.data_ok = 0; bus_if.rdata = 0;
        inst_cancel = 0;
        pend = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    // Full fetch with 1-cycle bus answers; expects normal delivery.
    task automatic run_inst(input logic [31:0] a, input logic [31:0] rd, input string tag);
        inst_if.req = 1; inst_if.addr = a;
        settle();
        chk({tag, ".addr_ok"}, inst_if.addr_ok, 1);
        chk({tag, ".req0"}, bus_if.req, 0);
        edge_t();
        inst_if.req = 0; bus_if.addr_ok = 1;
        settle();
        chk({tag, ".bus_req"}, bus_if.req, 1);
        chk({tag, ".bus_addr"}, bus_if.addr, a);
        edge_t();
        bus_if.addr_ok = 0; bus_if.data_ok = 1; bus_if.rdata = rd;
        settle();
        chk({tag, ".data_ok"}, inst_if.data_ok, 1);
        chk({tag, ".rdata"}, inst_if.rdata, rd);
        edge_t();
        bus_if.data_ok = 0;
        settle();
        chk({tag, ".data_ok_end"}, inst_if.data_ok, 0);
        edge_t();
    endtask

    // Fetch granted and accepted; returns at drive point of first WAIT cycle.
    task automatic inst_to_wait(input logic [31:0] a);
        inst_if.req = 1; inst_if.addr = a;
        settle();
        edge_t();
        inst_if.req = 0; bus_if.addr_ok = 1;
        settle();
        edge_t();
        bus_if.addr_ok = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit got expired want finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        byte unsigned got [10];
        byte unsigned expv [10];
        int n, streak, cnt;
        bit m_busy, m_owner, m_cancel, m_aph, m_wr, was_idle, ei, ed;
        bit i_gnt, d_gnt, pend_nx;
        logic [31:0] m_addr, m_wdata, m_rd;
        logic [3:0] m_wstrb;
        int dcnt;

        vt[0] = '{0, 1, 4'hf, 32'hbfc00000, 32'hdeadbeef, 32'h3c087fff, 0, 4'h0, 32'h0};
        vt[1] = '{1, 0, 4'hf, 32'h00001000, 32'h55aa55aa, 32'h01234567, 0, 4'h0, 32'h55aa55aa};
        vt[2] = '{1, 1, 4'h3, 32'h00000004, 32'h1234abcd, 32'h0, 1, 4'h3, 32'h1234abcd};
        vt[3] = '{1, 1, 4'hf, 32'hfffffffc, 32'hffffffff, 32'h0, 1, 4'hf, 32'hffffffff};
        vt[4] = '{0, 0, 4'h0, 32'hbfc0037c, 32'h0, 32'h8fbf0010, 0, 4'h0, 32'h0};
        vt[5] = '{1, 1, 4'h8, 32'h00000000, 32'h89abcdef, 32'h0, 1, 4'h8, 32'h89abcdef};

        do_reset();
        settle();
        chk("rst.bus_req", bus_if.req, 0);
        chk("rst.bus_wr", bus_if.wr, 0);
        chk("rst.bus_wstrb", bus_if.wstrb, 0);
        chk("rst.bus_addr", bus_if.addr, 0);
        chk("rst.bus_wdata", bus_if.wdata, 0);
        chk("rst.inst_data_ok", inst_if.data_ok, 0);
        chk("rst.data_data_ok", data_if.data_ok, 0);
        chk("rst.addr_oks", {inst_if.addr_ok, data_if.addr_ok}, 0);
        edge_t();

        for (int i = 0; i < 6; i++) begin
            v = vt[i];
            if (v.is_data) begin
                data_if.req = 1; data_if.wr = v.wr; data_if.wstrb = v.wstrb;
                data_if.addr = v.addr; data_if.wdata = v.wdata;
            end else begin
                inst_if.req = 1; inst_if.wr = v.wr; inst_if.wstrb = v.wstrb;
                inst_if.addr = v.addr; inst_if.wdata = v.wdata;
            end
            settle();
            chk($sformatf("tv%0d.inst_addr_ok", i), inst_if.addr_ok, !v.is_data);
            chk($sformatf("tv%0d.data_addr_ok", i), data_if.addr_ok, v.is_data);
            edge_t();
            inst_if.req = 0; data_if.req = 0; bus_if.addr_ok = 1;
            settle();
            chk($sformatf("tv%0d.bus_req", i), bus_if.req, 1);
            chk($sformatf("tv%0d.bus_addr", i), bus_if.addr, v.addr);
            chk($sformatf("tv%0d.bus_wr", i), bus_if.wr, v.exp_wr);
            chk($sformatf("tv%0d.bus_wstrb", i), bus_if.wstrb, v.exp_wstrb);
            chk($sformatf("tv%0d.bus_wdata", i), bus_if.wdata, v.exp_wdata);
            edge_t();
            bus_if.addr_ok = 0; bus_if.data_ok = 1; bus_if.rdata = v.rdata;
            settle();
            chk($sformatf("tv%0d.inst_data_ok", i), inst_if.data_ok, !v.is_data);
            chk($sformatf("tv%0d.data_data_ok", i), data_if.data_ok, v.is_data);
            if (v.is_data) chk($sformatf("tv%0d.rdata", i), data_if.rdata, v.rdata);
            else chk($sformatf("tv%0d.rdata", i), inst_if.rdata, v.rdata);
            edge_t();
            bus_if.data_ok = 0;
            settle();
            chk($sformatf("tv%0d.idle_req", i), bus_if.req, 0);
            edge_t();
        end

        // contention: data first, fetch only after return to IDLE
        do_reset();
        inst_if.req = 1; inst_if.addr = 32'hbfc00000;
        data_if.req = 1; data_if.wr = 0; data_if.addr = 32'h00001000;
        settle();
        chk("cont.data_first", data_if.addr_ok, 1);
        chk("cont.inst_wait0", inst_if.addr_ok, 0);
        edge_t();
        data_if.req = 0; bus_if.addr_ok = 1;
        settle();
        chk("cont.inst_wait1", inst_if.addr_ok, 0);
        edge_t();
        bus_if.addr_ok = 0; bus_if.data_ok = 1; bus_if.rdata = 32'ha5a5a5a5;
        settle();
        chk("cont.data_ok", data_if.data_ok, 1);
        chk("cont.data_rdata", data_if.rdata, 32'ha5a5a5a5);
        chk("cont.inst_wait2", inst_if.addr_ok, 0);
        edge_t();
        bus_if.data_ok = 0;
        settle();
        chk("cont.inst_grant", inst_if.addr_ok, 1);
        edge_t();
        inst_if.req = 0; bus_if.addr_ok = 1;
        settle();
        chk("cont.inst_addr", bus_if.addr, 32'hbfc00000);
        edge_t();
        bus_if.addr_ok = 0; bus_if.data_ok = 1;
        settle();
        chk("cont.inst_data_ok", inst_if.data_ok, 1);
        edge_t();
        bus_if.data_ok = 0;

        // starvation: both held, expected order from the fairness rule
        do_reset();
        streak = 0;
        for (int k = 0; k < 10; k++) begin
            if (streak == SMAX) begin expv[k] = "I"; streak = 0; end
            else begin expv[k] = "D"; streak++; end
        end
        inst_if.req = 1; inst_if.addr = 32'hbfc00010;
        data_if.req = 1; data_if.addr = 32'h00002000;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            bus_if.addr_ok = bus_if.req & ~pend;
            bus_if.data_ok = pend;
            settle();
            if (inst_if.addr_ok) begin got[n] = "I"; n++; end
            else if (data_if.addr_ok) begin got[n] = "D"; n++; end
            if (bus_if.addr_ok) pend = 1;
            else if (bus_if.data_ok) pend = 0;
            edge_t();
        end
        chk("starve.grants", n, 10);
        for (int k = 0; k < n; k++) chk($sformatf("starve.g%0d", k), got[k], expv[k]);

        // cancel in WAIT, bus answers 3 cycles later
        do_reset();
        inst_to_wait(32'hbfc00100);
        inst_cancel = 1;
        settle();
        chk("cancel.no_ok0", inst_if.data_ok, 0);
        edge_t();
        inst_cancel = 0;
        repeat (2) begin settle(); edge_t(); end
        bus_if.data_ok = 1; bus_if.rdata = 32'h11111111;
        settle();
        chk("cancel.dropped", inst_if.data_ok, 0);
        chk("cancel.no_data_ok", data_if.data_ok, 0);
        edge_t();
        bus_if.data_ok = 0;
        run_inst(32'hbfc0037c, 32'h8fbf0010, "after_cancel");

        // cancel in the same cycle as bus_data_ok
        inst_to_wait(32'hbfc00200);
        inst_cancel = 1; bus_if.data_ok = 1;
        settle();
        chk("cancel_same.dropped", inst_if.data_ok, 0);
        edge_t();
        inst_cancel = 0; bus_if.data_ok = 0;
        run_inst(32'hbfc00204, 32'h24080001, "after_same");

        // cancel has no effect on data
        data_if.req = 1; data_if.wr = 0; data_if.addr = 32'h00000040;
        settle();
        edge_t();
        data_if.req = 0; bus_if.addr_ok = 1; inst_cancel = 1;
        settle();
        edge_t();
        bus_if.addr_ok = 0; bus_if.data_ok = 1; bus_if.rdata = 32'hcafef00d;
        settle();
        chk("cancel_data.ok", data_if.data_ok, 1);
        chk("cancel_data.rdata", data_if.rdata, 32'hcafef00d);
        edge_t();
        bus_if.data_ok = 0; inst_cancel = 0;

        // addr_ok and data_ok together in ADDR: data_ok comes later
        inst_if.req = 1; inst_if.addr = 32'hbfc00300;
        settle();
        edge_t();
        inst_if.req = 0; bus_if.addr_ok = 1; bus_if.data_ok = 1;
        settle();
        chk("simul.no_ok", inst_if.data_ok, 0);
        edge_t();
        bus_if.addr_ok = 0; bus_if.data_ok = 0;
        settle();
        chk("simul.req_low", bus_if.req, 0);
        edge_t();
        bus_if.data_ok = 1;
        settle();
        chk("simul.late_ok", inst_if.data_ok, 1);
        edge_t();
        bus_if.data_ok = 0;

        // write payload stable while the bus stalls
        data_if.req = 1; data_if.wr = 1; data_if.wstrb = 4'b0011;
        data_if.addr = 32'h00000004; data_if.wdata = 32'h1234abcd;
        settle();
        chk("wr.addr_ok", data_if.addr_ok, 1);
        edge_t();
        data_if.req = 0; data_if.addr = 32'hffff0000;
        data_if.wdata = 0; data_if.wstrb = 4'hf;
        for (int k = 0; k < 4; k++) begin
            bus_if.addr_ok = (k == 3);
            settle();
            chk($sformatf("wr.c%0d.req", k), bus_if.req, 1);
            chk($sformatf("wr.c%0d.addr", k), bus_if.addr, 32'h00000004);
            chk($sformatf("wr.c%0d.wr", k), bus_if.wr, 1);
            chk($sformatf("wr.c%0d.wstrb", k), bus_if.wstrb, 4'b0011);
            chk($sformatf("wr.c%0d.wdata", k), bus_if.wdata, 32'h1234abcd);
            edge_t();
        end
        bus_if.addr_ok = 0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            bus_if.data_ok = (k == 1);
            settle();
            cnt += int'(data_if.data_ok);
            edge_t();
        end
        chk("wr.one_pulse", cnt, 1);
        bus_if.data_ok = 0;

        // async reset in ADDR and in WAIT
        inst_if.req = 1; inst_if.addr = 32'hbfc00400;
        settle();
        edge_t();
        inst_if.req = 0;
        settle();
        chk("rst_addr.req_before", bus_if.req, 1);
        reset = 1;
        #1;
        chk("rst_addr.req", bus_if.req, 0);
        chk("rst_addr.addr", bus_if.addr, 0);
        edge_t();
        reset = 0;
        inst_to_wait(32'hbfc00500);
        settle();
        reset = 1; bus_if.data_ok = 1;
        #1;
        chk("rst_wait.req", bus_if.req, 0);
        chk("rst_wait.addr", bus_if.addr, 0);
        chk("rst_wait.no_ok", inst_if.data_ok, 0);
        edge_t();
        reset = 0;
        settle();
        chk("rst_wait.after_ok", {inst_if.data_ok, data_if.data_ok}, 0);
        edge_t();
        bus_if.data_ok = 0;

        // random traffic vs transaction model
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        streak = 0; m_busy = 0; m_owner = 0; m_cancel = 0; m_aph = 0;
        m_wr = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; m_rd = 0;
        i_gnt = 0; d_gnt = 0; dcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (i_gnt) inst_if.req = 0;
            else if (!inst_if.req && $urandom_range(0, 2) == 0) begin
                inst_if.req = 1;
                inst_if.addr = 32'hbfc00000 | ($urandom & 32'h3c);
                inst_if.wr = 1'($urandom); inst_if.wstrb = 4'($urandom);
                inst_if.wdata = $urandom;
            end
            if (d_gnt) data_if.req = 0;
            else if (!data_if.req && $urandom_range(0, 1) == 0) begin
                data_if.req = 1; data_if.wr = 1'($urandom);
                data_if.wstrb = 4'($urandom);
                data_if.addr = 32'h00001000 | ($urandom & 32'h3c);
                data_if.wdata = $urandom;
            end
            inst_cancel = ($urandom_range(0, 7) == 0);
            bus_if.addr_ok = 0; bus_if.data_ok = 0; bus_if.rdata = $urandom;
            if (pend) begin
                if (dcnt == 0) begin
                    bus_if.data_ok = 1;
                    if (!m_wr) bus_if.rdata = mem[m_addr[5:2]];
                end else dcnt--;
            end else if (bus_if.req && $urandom_range(0, 1) == 1) begin
                bus_if.addr_ok = 1;
                bus_if.data_ok = ($urandom_range(0, 3) == 0);
            end
            settle();
            pend_nx = pend;
            was_idle = !m_busy;
            if (m_busy && !m_owner && inst_cancel) m_cancel = 1;
            chk("rnd.bus_req", bus_if.req, m_aph);
            if (pend && bus_if.data_ok) begin
                chk("rnd.inst_data_ok", inst_if.data_ok, !m_owner && !m_cancel);
                chk("rnd.data_data_ok", data_if.data_ok, m_owner);
                if (!m_owner && !m_cancel) chk("rnd.inst_rdata", inst_if.rdata, m_rd);
                if (m_owner && !m_wr) chk("rnd.data_rdata", data_if.rdata, m_rd);
                m_busy = 0; pend_nx = 0;
            end else begin
                chk("rnd.no_data_ok", {inst_if.data_ok, data_if.data_ok}, 0);
            end
            if (!pend && bus_if.addr_ok && bus_if.req) begin
                chk("rnd.acc_addr", bus_if.addr, m_addr);
                chk("rnd.acc_wr", bus_if.wr, m_wr);
                chk("rnd.acc_wstrb", bus_if.wstrb, m_wstrb);
                chk("rnd.acc_wdata", bus_if.wdata, m_wdata);
                if (m_wr)
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
                m_aph = 0; pend_nx = 1; dcnt = $urandom_range(0, 3);
            end
            ei = 0; ed = 0;
            if (was_idle && (inst_if.req || data_if.req)) begin
                if (data_if.req && !(inst_if.req && streak == SMAX)) ed = 1;
                else ei = 1;
            end
            chk("rnd.inst_addr_ok", inst_if.addr_ok, ei);
            chk("rnd.data_addr_ok", data_if.addr_ok, ed);
            if (ei) begin
                m_busy = 1; m_owner = 0; m_cancel = 0; m_aph = 1; streak = 0;
                m_addr = inst_if.addr; m_wr = 0; m_wstrb = 0; m_wdata = 0;
                m_rd = mem[inst_if.addr[5:2]];
            end
            if (ed) begin
                m_busy = 1; m_owner = 1; m_cancel = 0; m_aph = 1;
                if (inst_if.req && streak < SMAX) streak++;
                m_addr = data_if.addr; m_wr = data_if.wr;
                m_wstrb = data_if.wr ? data_if.wstrb : 4'h0;
                m_wdata = data_if.wdata; m_rd = mem[data_if.addr[5:2]];
            end
            i_gnt = inst_if.addr_ok; d_gnt = data_if.addr_ok;
            pend = pend_nx;
            edge_t();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
